// File: rtl/button_gesture.sv
// Gesture classifier: turns a debounced button level into click / double-click / long-press pulses.
// Optional feature macro: GESTURE_DOUBLE_EN enables the release gap window and double-click detection.
module button_gesture #(
  parameter int LONG_LIMIT = 12500000,
  parameter int GAP_LIMIT  = 6250000
) (
  input  logic clock,
  input  logic reset,
  input  logic in_0,
  output logic click_0,
  output logic double_0,
  output logic long_0,
  output logic busy_0
);

  localparam int MAX_LIMIT = (LONG_LIMIT > GAP_LIMIT) ? LONG_LIMIT : GAP_LIMIT;
  localparam int CW        = $clog2(MAX_LIMIT + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_LIMIT - 1);

`ifdef GESTURE_DOUBLE_EN
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HELD
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    PRESS1,
    LONG_HELD
  } state_t;
`endif

  state_t        state, next_state;
  logic [CW-1:0] count, next_count;
  logic          prev;
  logic          next_click, next_double, next_long;

  always_comb begin
    next_state  = state;
    next_count  = count;
    next_click  = 1'b0;
    next_double = 1'b0;
    next_long   = 1'b0;
    case (state)
      IDLE: begin
        if (in_0 && !prev) begin
          next_state = PRESS1;
          next_count = '0;
        end
      end
      PRESS1: begin
        if (in_0) begin
          if (count == LONG_LAST) begin
            next_long  = 1'b1;
            next_state = LONG_HELD;
            next_count = '0;
          end else begin
            next_count = count + 1'b1;
          end
        end else begin
`ifdef GESTURE_DOUBLE_EN
          next_state = WAIT_GAP;
          next_count = '0;
`else
          next_click = 1'b1;
          next_state = IDLE;
          next_count = '0;
`endif
        end
      end
`ifdef GESTURE_DOUBLE_EN
      // The gap timeout wins over a press landing on the very last gap cycle,
      // so the double-click window is strictly r+1 .. r+GAP_LIMIT-1.
      WAIT_GAP: begin
        if (count == GAP_LAST) begin
          next_click = 1'b1;
          next_state = IDLE;
          next_count = '0;
        end else if (in_0) begin
          next_state = PRESS2;
          next_count = '0;
        end else begin
          next_count = count + 1'b1;
        end
      end
      PRESS2: begin
        if (!in_0) begin
          next_double = 1'b1;
          next_state  = IDLE;
          next_count  = '0;
        end
      end
`endif
      LONG_HELD: begin
        if (!in_0) begin
          next_state = IDLE;
          next_count = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  // prev resets high so a button held through reset must be released first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      prev    <= 1'b1;
      click_0 <= 1'b0;
      long_0  <= 1'b0;
      busy_0  <= 1'b0;
    end else begin
      state   <= next_state;
      count   <= next_count;
      prev    <= in_0;
      click_0 <= next_click;
      long_0  <= next_long;
      busy_0  <= (next_state != IDLE);
    end
  end

`ifdef GESTURE_DOUBLE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      double_0 <= 1'b0;
    end else begin
      double_0 <= next_double;
    end
  end
`else
  assign double_0 = 1'b0;
`endif

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture with LONG_LIMIT=8, GAP_LIMIT=4.
// Expectations follow the GESTURE_DOUBLE_EN setting of the build.
module tb_button_gesture;

  localparam int LONG_LIMIT = 8;
  localparam int GAP_LIMIT  = 4;
  localparam int NUM_VECS   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_0  = 1'b0;
  logic click_0, double_0, long_0, busy_0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  button_gesture #(
    .LONG_LIMIT(LONG_LIMIT),
    .GAP_LIMIT (GAP_LIMIT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in_0    (in_0),
    .click_0 (click_0),
    .double_0(double_0),
    .long_0  (long_0),
    .busy_0  (busy_0)
  );

  // Bit e of each mask is the input level at edge e, or the expected output just after edge e.
  typedef struct {
    string       name;
    int          edges;
    logic [31:0] press;
    logic [31:0] click;
    logic [31:0] dbl;
    logic [31:0] lng;
    logic [31:0] busy;
  } vec_t;

  vec_t vecs [NUM_VECS];

  task automatic apply_stimulus(input logic rst, input logic level);
    reset = rst;
    in_0  = level;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input int edge_idx, input logic [3:0] expected);
    logic [3:0] actual;
    actual = {click_0, double_0, long_0, busy_0};
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s edge %0d: click/double/long/busy got %b expected %b",
               name, edge_idx, actual, expected);
    end
  endtask

  task automatic run_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, 1'b0);
      check_output(name, i, 4'b0000);
    end
  endtask

  task automatic run_vector(input int idx);
    vec_t v;
    v = vecs[idx];
    for (int e = 0; e < v.edges; e++) begin
      apply_stimulus(1'b0, v.press[e]);
      check_output(v.name, e, {v.click[e], v.dbl[e], v.lng[e], v.busy[e]});
    end
  endtask

  initial begin
`ifdef GESTURE_DOUBLE_EN
    vecs[0] = '{"single",        10, 32'h0000_0007, 32'h0000_0080, 32'h0000_0000, 32'h0000_0000, 32'h0000_007F};
    vecs[1] = '{"double",        10, 32'h0000_0067, 32'h0000_0000, 32'h0000_0080, 32'h0000_0000, 32'h0000_007F};
    vecs[2] = '{"double_early",   8, 32'h0000_0037, 32'h0000_0000, 32'h0000_0040, 32'h0000_0000, 32'h0000_003F};
    vecs[3] = '{"double_late",    9, 32'h0000_0047, 32'h0000_0000, 32'h0000_0080, 32'h0000_0000, 32'h0000_007F};
    vecs[4] = '{"gap_boundary",  12, 32'h0000_0187, 32'h0000_0080, 32'h0000_0000, 32'h0000_0000, 32'h0000_007F};
    vecs[5] = '{"long",          24, 32'h001F_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'h001F_FFFF};
    vecs[6] = '{"long_boundary", 16, 32'h0000_00FF, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0FFF};
    vecs[7] = '{"long_second",   18, 32'h0000_FFF7, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_FFFF};
`else
    vecs[0] = '{"single",        10, 32'h0000_0007, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 32'h0000_0007};
    vecs[1] = '{"double",        10, 32'h0000_0067, 32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 32'h0000_0067};
    vecs[2] = '{"double_early",   8, 32'h0000_0037, 32'h0000_0048, 32'h0000_0000, 32'h0000_0000, 32'h0000_0037};
    vecs[3] = '{"double_late",    9, 32'h0000_0047, 32'h0000_0088, 32'h0000_0000, 32'h0000_0000, 32'h0000_0047};
    vecs[4] = '{"gap_boundary",  12, 32'h0000_0187, 32'h0000_0208, 32'h0000_0000, 32'h0000_0000, 32'h0000_0187};
    vecs[5] = '{"long",          24, 32'h001F_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'h001F_FFFF};
    vecs[6] = '{"long_boundary", 16, 32'h0000_00FF, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 32'h0000_00FF};
    vecs[7] = '{"long_second",   18, 32'h0000_FFF7, 32'h0000_0008, 32'h0000_0000, 32'h0000_1000, 32'h0000_FFF7};
`endif

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0);
      check_output("reset", i, 4'b0000);
    end
    run_idle("post_reset", 3);

    for (int i = 0; i < NUM_VECS; i++) begin
      run_vector(i);
      run_idle("between", 3);
    end

    // Reset arrives mid-press; the still-held button must not start a gesture.
    apply_stimulus(1'b0, 1'b1);
    check_output("reset_mid", 0, 4'b0001);
    apply_stimulus(1'b0, 1'b1);
    check_output("reset_mid", 1, 4'b0001);
    apply_stimulus(1'b0, 1'b1);
    check_output("reset_mid", 2, 4'b0001);
    apply_stimulus(1'b1, 1'b1);
    check_output("reset_mid", 3, 4'b0000);
    for (int i = 4; i < 16; i++) begin
      apply_stimulus(1'b0, 1'b1);
      check_output("reset_mid_held", i, 4'b0000);
    end
    run_idle("reset_mid_release", 3);
    run_vector(0);
    run_idle("between", 3);

    // Button held from before reset release produces nothing until a 0 is sampled.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1);
      check_output("held_reset", i, 4'b0000);
    end
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0, 1'b1);
      check_output("held_after_reset", i, 4'b0000);
    end
    run_idle("held_release", 3);
    run_vector(0);
    run_idle("final", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
